periph_timer: RTL and testbench

- Memory-mapped down-counting timer on the peripheral side of an I/O slot.
- Responds to the slot's peripheral bus (io_addr, io_data, io_read, io_write, io_ready) with a wait-state handshake.
- Raises a level interrupt on expiry.
- First concrete peripheral behind the CPU's I/O address window; sets the responder protocol every later peripheral follows.

---
 rtl/periph_timer_pkg.sv | 32 +++
 rtl/periph_bus_responder.sv | 91 +++++++++
 rtl/periph_timer.sv | 135 +++++++++++++
 tb/tb_periph_timer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_timer_pkg.sv
// Shared register map, bit positions and bus-responder state encoding for I/O-slot peripherals.
// Pure declarations: no latency and no backpressure of its own.
package periph_timer_pkg;

    localparam int PERIPH_ADDR_WIDTH_DEF = 6;
    localparam int PERIPH_DATA_WIDTH_DEF = 32;

    localparam int TIMER_REG_CTRL   = 0;
    localparam int TIMER_REG_LOAD   = 1;
    localparam int TIMER_REG_COUNT  = 2;
    localparam int TIMER_REG_STATUS = 3;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int STATUS_EXPIRED   = 0;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_WAIT = 2'd1,
        BUS_ACK  = 2'd2,
        BUS_HOLD = 2'd3
    } bus_state_t;

    // Field order puts EN at bit 0, AUTO_RELOAD at bit 1, IRQ_EN at bit 2.
    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/periph_bus_responder.sv
// Slot-side wait-state responder: io_ready pulses WAIT_STATES+1 cycles after a request is seen.
// No backpressure beyond the slot holding its request; HOLD swallows held requests so each is acked once.
module periph_bus_responder
    import periph_timer_pkg::*;
#(
    parameter int AW          = PERIPH_ADDR_WIDTH_DEF,
    parameter int WAIT_STATES = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_io_addr,
    input  logic          i_io_read,
    input  logic          i_io_write,
    output logic          o_io_ready,
    output logic          o_wr_strobe,
    output logic          o_rd_strobe,
    output logic [AW-1:0] o_addr,
    output logic          o_data_oe
);

    localparam int WCW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    bus_state_t     r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic [AW-1:0]  r_addr;
    logic           r_is_write;
    logic           r_ready;

    logic w_req;
    logic w_enter_ack;
    logic w_dir_write;

    assign w_req       = i_io_read | i_io_write;
    assign w_enter_ack = ((r_state == BUS_IDLE) && w_req && (WAIT_STATES == 0)) ||
                         ((r_state == BUS_WAIT) && (r_wait_cnt == WAIT_LAST));

    // Strobes fire on the edge entering ACK, while the slot is still guaranteed to hold data.
    assign w_dir_write = (r_state == BUS_IDLE) ? i_io_write : r_is_write;
    assign o_addr      = (r_state == BUS_IDLE) ? i_io_addr  : r_addr;
    assign o_wr_strobe = w_enter_ack && w_dir_write && i_io_write;
    assign o_rd_strobe = w_enter_ack && !w_dir_write;
    assign o_data_oe   = i_io_read && !r_is_write &&
                         ((r_state == BUS_ACK) || (r_state == BUS_HOLD));
    assign o_io_ready  = r_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= BUS_IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_is_write <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                BUS_IDLE: begin
                    if (w_req) begin
                        r_addr     <= i_io_addr;
                        r_is_write <= i_io_write;
                        r_wait_cnt <= '0;
                        if (WAIT_STATES == 0) begin
                            r_state <= BUS_ACK;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= BUS_WAIT;
                        end
                    end
                end
                BUS_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_state <= BUS_ACK;
                        r_ready <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                BUS_ACK: begin
                    r_state <= BUS_HOLD;
                end
                BUS_HOLD: begin
                    if (!w_req) begin
                        r_state <= BUS_IDLE;
                    end
                end
                default: r_state <= BUS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/periph_timer.sv
// Memory-mapped prescaled down-counter with sticky expiry and level irq behind an I/O slot.
// Bus ack WAIT_STATES+1 cycles after request; the slot holds the request until io_ready.
module periph_timer
    import periph_timer_pkg::*;
#(
    parameter int PERIPH_ADDR_WIDTH = PERIPH_ADDR_WIDTH_DEF,
    parameter int PERIPH_DATA_WIDTH = PERIPH_DATA_WIDTH_DEF,
    parameter int WAIT_STATES       = 1,
    parameter int PRESCALE          = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PERIPH_ADDR_WIDTH-1:0] io_addr,
    inout  wire  [PERIPH_DATA_WIDTH-1:0] io_data,
    input  logic                         io_read,
    input  logic                         io_write,
    output logic                         io_ready,
    output logic                         irq
);

    localparam int AW  = PERIPH_ADDR_WIDTH;
    localparam int DW  = PERIPH_DATA_WIDTH;
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESCALE - 1);

    logic          w_wr;
    logic          w_rd;
    logic [AW-1:0] w_addr;
    logic          w_oe;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rd_mux;
    ctrl_t         w_new_ctrl;
    logic          w_wr_ctrl, w_wr_load, w_wr_count, w_wr_status;
    logic          w_presc_wrap, w_tick, w_expire;

    ctrl_t         r_ctrl;
    logic [DW-1:0] r_load;
    logic [DW-1:0] r_count;
    logic          r_expired;
    logic [PSW-1:0] r_presc;
    logic [DW-1:0] r_rd_data;

    periph_bus_responder #(
        .AW          (AW),
        .WAIT_STATES (WAIT_STATES)
    ) u_resp (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_io_addr   (io_addr),
        .i_io_read   (io_read),
        .i_io_write  (io_write),
        .o_io_ready  (io_ready),
        .o_wr_strobe (w_wr),
        .o_rd_strobe (w_rd),
        .o_addr      (w_addr),
        .o_data_oe   (w_oe)
    );

    assign w_wdata     = io_data;
    assign io_data     = w_oe ? r_rd_data : 'z;
    assign w_new_ctrl  = ctrl_t'(w_wdata[2:0]);
    assign w_wr_ctrl   = w_wr && (w_addr == AW'(TIMER_REG_CTRL));
    assign w_wr_load   = w_wr && (w_addr == AW'(TIMER_REG_LOAD));
    assign w_wr_count  = w_wr && (w_addr == AW'(TIMER_REG_COUNT));
    assign w_wr_status = w_wr && (w_addr == AW'(TIMER_REG_STATUS));

    // A CTRL write that clears EN suppresses a coincident tick entirely.
    assign w_presc_wrap = (r_presc == PRESC_LAST);
    assign w_tick       = r_ctrl.en && w_presc_wrap && !(w_wr_ctrl && !w_new_ctrl.en);
    assign w_expire     = w_tick && (r_count == '0);
    assign irq          = r_expired && r_ctrl.irq_en;

    always_comb begin
        w_rd_mux = '0;
        if (w_addr == AW'(TIMER_REG_CTRL)) begin
            w_rd_mux[2:0] = r_ctrl;
        end else if (w_addr == AW'(TIMER_REG_LOAD)) begin
            w_rd_mux = r_load;
        end else if (w_addr == AW'(TIMER_REG_COUNT)) begin
            w_rd_mux = r_count;
        end else if (w_addr == AW'(TIMER_REG_STATUS)) begin
            w_rd_mux[STATUS_EXPIRED] = r_expired;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl    <= '0;
            r_load    <= '0;
            r_count   <= '0;
            r_expired <= 1'b0;
            r_presc   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_rd) begin
                r_rd_data <= w_rd_mux;
            end

            if (w_wr_ctrl && (!w_new_ctrl.en || !r_ctrl.en)) begin
                r_presc <= '0;
            end else if (!r_ctrl.en || w_presc_wrap) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (w_wr_ctrl) begin
                r_ctrl <= w_new_ctrl;
            end else if (w_expire && !r_ctrl.auto_reload) begin
                r_ctrl.en <= 1'b0;
            end

            if (w_wr_load) begin
                r_load <= w_wdata;
            end

            if (w_wr_count) begin
                r_count <= w_wdata;
            end else if (w_tick) begin
                if (r_count != '0) begin
                    r_count <= r_count - 1'b1;
                end else if (r_ctrl.auto_reload) begin
                    r_count <= r_load;
                end
            end

            if (w_expire) begin
                r_expired <= 1'b1;
            end else if (w_wr_status && w_wdata[STATUS_EXPIRED]) begin
                r_expired <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_periph_timer.sv
// Bench for periph_timer: scenario tasks with a read-data scoreboard, cycle-aligned against prescaler ticks.
// A second WAIT_STATES=0 instance checks the zero-wait acknowledge.
module tb_periph_timer;

    localparam int WS  = 1;
    localparam int PRE = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [5:0]  io_addr = '0;
    logic        io_read = 1'b0, io_write = 1'b0;
    logic        tb_oe = 1'b0;
    logic [31:0] tb_dat = '0;
    tri1  [31:0] io_data;
    logic        io_ready, irq;
    assign io_data = tb_oe ? tb_dat : 'z;

    logic [5:0]  io_addr0 = '0;
    logic        io_read0 = 1'b0, io_write0 = 1'b0;
    logic        tb_oe0 = 1'b0;
    logic [31:0] tb_dat0 = '0;
    tri1  [31:0] io_data0;
    logic        io_ready0, irq0;
    assign io_data0 = tb_oe0 ? tb_dat0 : 'z;

    periph_timer #(.PERIPH_ADDR_WIDTH(6), .PERIPH_DATA_WIDTH(32), .WAIT_STATES(WS), .PRESCALE(PRE)) dut (
        .clk(clk), .reset(reset), .io_addr(io_addr), .io_data(io_data),
        .io_read(io_read), .io_write(io_write), .io_ready(io_ready), .irq(irq));

    periph_timer #(.PERIPH_ADDR_WIDTH(6), .PERIPH_DATA_WIDTH(32), .WAIT_STATES(0), .PRESCALE(PRE)) dut0 (
        .clk(clk), .reset(reset), .io_addr(io_addr0), .io_data(io_data0),
        .io_read(io_read0), .io_write(io_write0), .io_ready(io_ready0), .irq(irq0));

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic wait_cyc(input int n);
        checks++;
        if (cyc > n) begin
            errors++;
            $display("FAIL schedule: now at cycle %0d, required not later than %0d", cyc, n);
        end
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    // at>0 lands the ACK-entry edge on cycle 'at'.
    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input int at,
                             output int lat, output int commit);
        if (at > 0) wait_cyc(at - 1 - WS);
        io_addr = a; tb_dat = d; tb_oe = 1'b1; io_write = 1'b1;
        lat = 0; commit = -1;
        do begin @(posedge clk); #1; lat++; end while (!io_ready && lat < 20);
        if (!io_ready) begin
            checks++; errors++;
            $display("FAIL write_timeout: addr %0d no io_ready after %0d cycles", a, lat);
        end else begin
            commit = cyc;
        end
        io_write = 1'b0; tb_oe = 1'b0;
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic bus_read(input logic [5:0] a, input int at, output logic [31:0] d,
                            output int lat, output logic [31:0] after_drop);
        if (at > 0) wait_cyc(at - 1 - WS);
        io_addr = a; io_read = 1'b1;
        lat = 0; d = 'x;
        do begin @(posedge clk); #1; lat++; end while (!io_ready && lat < 20);
        if (!io_ready) begin
            checks++; errors++;
            $display("FAIL read_timeout: addr %0d no io_ready after %0d cycles", a, lat);
        end else begin
            d = io_data;
        end
        io_read = 1'b0; #1;
        after_drop = io_data;
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d, z, e;
        int lat;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (io_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", io_ready); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++; if (io_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_bus_z: got %h want released", io_data); end
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            bus_read(6'(i), 0, d, lat, z);
            e = exp_q.pop_front();
            checks++; if (d !== e) begin errors++; $display("FAIL reset_reg%0d: got %h want %h", i, d, e); end
        end
    endtask

    task automatic test_bus_basic();
        logic [31:0] d, z, e;
        int lat, c;
        bus_write(6'd1, 32'd5, 0, lat, c);
        checks++; if (lat != WS + 1) begin errors++; $display("FAIL write_latency: got %0d want %0d", lat, WS + 1); end
        exp_q.push_back(32'd5);
        bus_read(6'd1, 0, d, lat, z);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL read_load: got %h want %h", d, e); end
        checks++; if (lat != WS + 1) begin errors++; $display("FAIL read_latency: got %0d want %0d", lat, WS + 1); end
        checks++; if (z !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bus_release: got %h want released", z); end
    endtask

    task automatic test_count_down();
        logic [31:0] d, z, e;
        int lat, c, en_at;
        bus_write(6'd2, 32'd3, 0, lat, c);
        bus_write(6'd0, 32'h1, 0, lat, en_at);
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(32'(3 - k));
            bus_read(6'd2, en_at + PRE * k + 4, d, lat, z);
            e = exp_q.pop_front();
            checks++; if (d !== e) begin errors++; $display("FAIL countdown_step%0d: got %0d want %0d", k, d, e); end
        end
        exp_q.push_back(32'h1);
        bus_read(6'd3, en_at + PRE * 4 + 4, d, lat, z);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL countdown_expired: got %h want %h", d, e); end
        exp_q.push_back(32'h0);
        bus_read(6'd0, 0, d, lat, z);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL countdown_en_cleared: got %h want %h", d, e); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL countdown_irq_masked: got %b want 0", irq); end
    endtask

    task automatic test_auto_reload();
        logic [31:0] d, z, e;
        int lat, c, en_at, clr_at;
        bus_write(6'd3, 32'h1, 0, lat, c);
        bus_write(6'd1, 32'd2, 0, lat, c);
        bus_write(6'd0, 32'h7, 0, lat, en_at);
        wait_cyc(en_at + PRE - 1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reload_irq_pre1: got %b want 0", irq); end
        wait_cyc(en_at + PRE);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL reload_irq_rise1: got %b want 1", irq); end
        clr_at = en_at + PRE + 4;
        wait_cyc(clr_at - 1 - WS);
        io_addr = 6'd3; tb_dat = 32'h1; tb_oe = 1'b1; io_write = 1'b1;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!io_ready && lat < 20);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL status_clear_irq: got %b want 0 at ack", irq); end
        io_write = 1'b0; tb_oe = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        wait_cyc(en_at + 4 * PRE - 1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reload_irq_pre2: got %b want 0", irq); end
        wait_cyc(en_at + 4 * PRE);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL reload_irq_rise2: got %b want 1", irq); end
        exp_q.push_back(32'd2);
        bus_read(6'd2, en_at + 4 * PRE + 4, d, lat, z);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL reload_count: got %0d want %0d", d, e); end
        bus_write(6'd0, 32'h0, 0, lat, c);
        bus_write(6'd3, 32'h1, 0, lat, c);
    endtask

    task automatic test_hold_and_unmapped();
        logic [31:0] d, z, e;
        int lat, c, pulses;
        logic [31:0] exp_regs[4];
        bus_write(6'd2, 32'h55, 0, lat, c);
        io_addr = 6'd1; tb_dat = 32'h11; tb_oe = 1'b1; io_write = 1'b1;
        pulses = 0; lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!io_ready && lat < 20);
        if (io_ready) pulses++;
        tb_dat = 32'h22;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (io_ready) pulses++;
        end
        io_write = 1'b0; tb_oe = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (pulses != 1) begin errors++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
        exp_q.push_back(32'h11);
        bus_read(6'd1, 0, d, lat, z);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL hold_single_commit: got %h want %h", d, e); end
        exp_q.push_back(32'h0);
        bus_read(6'd9, 0, d, lat, z);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL unmapped_read: got %h want %h", d, e); end
        bus_write(6'd9, 32'hFFFF_FFFF, 0, lat, c);
        checks++; if (c < 0) begin errors++; $display("FAIL unmapped_ack: got no ack want ack"); end
        exp_regs[0] = 32'h0; exp_regs[1] = 32'h11; exp_regs[2] = 32'h55; exp_regs[3] = 32'h0;
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_regs[i]);
        for (int i = 0; i < 4; i++) begin
            bus_read(6'(i), 0, d, lat, z);
            e = exp_q.pop_front();
            checks++; if (d !== e) begin errors++; $display("FAIL unmapped_write_reg%0d: got %h want %h", i, d, e); end
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d, z, e;
        int lat, c, en_at;
        bus_write(6'd2, 32'd0, 0, lat, c);
        bus_write(6'd0, 32'h1, 0, lat, en_at);
        bus_write(6'd3, 32'h1, en_at + PRE, lat, c);
        exp_q.push_back(32'h1);
        bus_read(6'd3, 0, d, lat, z);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL set_beats_clear: got %h want %h", d, e); end
        bus_write(6'd3, 32'h1, 0, lat, c);
        exp_q.push_back(32'h0);
        bus_read(6'd3, 0, d, lat, z);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL status_w1c: got %h want %h", d, e); end
        bus_write(6'd2, 32'd20, 0, lat, c);
        bus_write(6'd0, 32'h1, 0, lat, en_at);
        bus_write(6'd2, 32'd7, en_at + PRE, lat, c);
        exp_q.push_back(32'd7);
        bus_read(6'd2, en_at + PRE + 4, d, lat, z);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL bus_beats_tick: got %0d want %0d", d, e); end
        exp_q.push_back(32'd6);
        bus_read(6'd2, en_at + 2 * PRE + 4, d, lat, z);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL tick_after_write: got %0d want %0d", d, e); end
        bus_write(6'd0, 32'h0, en_at + 3 * PRE, lat, c);
        exp_q.push_back(32'd6);
        bus_read(6'd2, en_at + 3 * PRE + 4, d, lat, z);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL disable_beats_tick: got %0d want %0d", d, e); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, z, e;
        int lat;
        io_addr = 6'd1; tb_dat = 32'h99; tb_oe = 1'b1; io_write = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++; if (io_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_ready: got %b want 0", io_ready); end
        @(posedge clk); #1;
        io_write = 1'b0; tb_oe = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            bus_read(6'(i), 0, d, lat, z);
            e = exp_q.pop_front();
            checks++; if (d !== e) begin errors++; $display("FAIL reset_mid_reg%0d: got %h want %h", i, d, e); end
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] d, e;
        int lat;
        io_addr0 = 6'd1; tb_dat0 = 32'hA5; tb_oe0 = 1'b1; io_write0 = 1'b1;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!io_ready0 && lat < 20);
        checks++; if (lat != 1) begin errors++; $display("FAIL ws0_write_latency: got %0d want 1", lat); end
        io_write0 = 1'b0; tb_oe0 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        exp_q.push_back(32'hA5);
        io_read0 = 1'b1;
        lat = 0; d = 'x;
        do begin @(posedge clk); #1; lat++; end while (!io_ready0 && lat < 20);
        if (io_ready0) d = io_data0;
        io_read0 = 1'b0;
        e = exp_q.pop_front();
        checks++; if (lat != 1) begin errors++; $display("FAIL ws0_read_latency: got %0d want 1", lat); end
        checks++; if (d !== e) begin errors++; $display("FAIL ws0_read_data: got %h want %h", d, e); end
        @(posedge clk); @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_bus_basic();
        test_count_down();
        test_auto_reload();
        test_hold_and_unmapped();
        test_simultaneous();
        test_reset_mid();
        test_zero_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
